// File: rtl/serial_word_packer.sv
// Packs the detector's qualified serial bit stream LSB-first into WIDTH-bit words
// and offers each word with its popcount through a one-entry valid/ready holding register.
module serial_word_packer #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CW = $clog2(WIDTH + 1),
  localparam int unsigned FW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_en,
  input  logic             word_ready,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] word_out,
  output logic [CW-1:0]    ones_out,
  output logic             word_valid,
  output logic [FW-1:0]    fill,
  output logic             overflow
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_e;

  state_e           state_q;
  logic [WIDTH-2:0] sr_q, sr_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [WIDTH-1:0] word_q;
  logic [CW-1:0]    ones_q;
  logic             ovf_q;

  logic [WIDTH-1:0] assembled_c;
  logic [CW-1:0]    ones_c;
  logic             complete_c;
  logic             load_c;
  logic             drop_c;

  function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] w);
    logic [CW-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      n = n + CW'(w[i]);
    end
    return n;
  endfunction

  // Collect bits into the partial word; the last bit bypasses sr straight into the word.
  always_comb begin
    sr_d        = sr_q;
    fill_d      = fill_q;
    complete_c  = 1'b0;
    assembled_c = {bit_in, sr_q};
    ones_c      = popcount(assembled_c);
    if (bit_en) begin
      if (fill_q == FW'(WIDTH - 1)) begin
        complete_c = 1'b1;
        fill_d     = '0;
      end else begin
        for (int unsigned i = 0; i < WIDTH - 1; i++) begin
          if (fill_q == FW'(i)) begin
            sr_d[i] = bit_in;
          end
        end
        fill_d = fill_q + FW'(1);
      end
    end
    load_c = complete_c && ((state_q == S_EMPTY) || word_ready);
    drop_c = complete_c && !load_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      sr_q    <= '0;
      fill_q  <= '0;
      word_q  <= '0;
      ones_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      fill_q <= fill_d;
      if (load_c) begin
        word_q <= assembled_c;
        ones_q <= ones_c;
      end
      case (state_q)
        S_EMPTY: if (load_c) state_q <= S_FULL;
        S_FULL:  if (word_ready && !load_c) state_q <= S_EMPTY;
        default: state_q <= S_EMPTY;
      endcase
      // A drop on the same edge as a clear keeps the flag set.
      if (drop_c) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign word_out   = word_q;
  assign ones_out   = ones_q;
  assign word_valid = (state_q == S_FULL);
  assign fill       = fill_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_serial_word_packer.sv
// Bench for serial_word_packer: directed scenarios plus random traffic, all checked
// against a queue-based reference of the packing and holding-register rules.
module tb_serial_word_packer;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned FW = $clog2(WIDTH);

  logic             clk = 1'b0;
  logic             rst, bit_in, bit_en, word_ready, ovf_clr;
  logic [WIDTH-1:0] word_out;
  logic [CW-1:0]    ones_out;
  logic             word_valid;
  logic [FW-1:0]    fill;
  logic             overflow;

  int checks = 0;
  int errors = 0;

  // Reference state
  bit               cur[$];
  logic [WIDTH-1:0] m_word;
  logic [CW-1:0]    m_ones;
  logic             m_valid;
  logic             m_ovf;

  serial_word_packer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_en(bit_en),
    .word_ready(word_ready), .ovf_clr(ovf_clr), .word_out(word_out),
    .ones_out(ones_out), .word_valid(word_valid), .fill(fill), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one clock of inputs, advance the reference, and compare every output.
  task automatic step(input logic r, input logic en, input logic b,
                      input logic rdy, input logic clr);
    logic [WIDTH-1:0] w;
    logic             dropped;
    @(negedge clk);
    rst = r; bit_en = en; bit_in = b; word_ready = rdy; ovf_clr = clr;
    dropped = 1'b0;
    if (r) begin
      cur.delete();
      m_word = '0; m_ones = '0; m_valid = 1'b0; m_ovf = 1'b0;
    end else begin
      if (m_valid && rdy) m_valid = 1'b0;
      if (en) begin
        cur.push_back(b);
        if (cur.size() == WIDTH) begin
          for (int i = 0; i < int'(WIDTH); i++) w[i] = cur[i];
          cur.delete();
          if (!m_valid) begin
            m_word  = w;
            m_ones  = CW'($countones(w));
            m_valid = 1'b1;
          end else begin
            dropped = 1'b1;
          end
        end
      end
      if (dropped) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("word_valid", 32'(word_valid), 32'(m_valid));
    chk("word_out",   32'(word_out),   32'(m_word));
    chk("ones_out",   32'(ones_out),   32'(m_ones));
    chk("fill",       32'(fill),       32'(cur.size()));
    chk("overflow",   32'(overflow),   32'(m_ovf));
  endtask

  task automatic feed(input logic [WIDTH-1:0] w, input logic rdy);
    for (int i = 0; i < int'(WIDTH); i++) step(1'b0, 1'b1, w[i], rdy, 1'b0);
  endtask

  initial begin
    logic [WIDTH-1:0] pat;
    rst = 1'b1; bit_en = 1'b0; bit_in = 1'b0; word_ready = 1'b0; ovf_clr = 1'b0;
    m_word = '0; m_ones = '0; m_valid = 1'b0; m_ovf = 1'b0;

    // Reset state
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("rst_word", 32'(word_out), 32'h0);
    chk("rst_valid", 32'(word_valid), 32'h0);

    // Continuous stream 1,0,1,1,0,0,0,1 with sink ready
    pat = 8'h8D;
    feed(pat, 1'b1);
    chk("t1_word", 32'(word_out), 32'h8D);
    chk("t1_ones", 32'(ones_out), 32'd4);
    chk("t1_valid", 32'(word_valid), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t1_valid_pulse", 32'(word_valid), 32'd0);

    // Same stream with bit_en toggling; junk bits on idle cycles
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, pat[i], 1'b1, 1'b0);
      step(1'b0, 1'b0, ~pat[i], 1'b1, 1'b0);
      if (i == 7) begin
        chk("t2_word", 32'(word_out), 32'h8D);
        chk("t2_valid", 32'(word_valid), 32'd0);
      end else begin
        chk("t2_fill_hold", 32'(fill), 32'(i + 1));
      end
    end

    // Overflow with stalled sink, then drain and clear
    feed(8'hFF, 1'b0);
    feed(8'h00, 1'b0);
    chk("t3_word", 32'(word_out), 32'hFF);
    chk("t3_ones", 32'(ones_out), 32'd8);
    chk("t3_ovf", 32'(overflow), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t3_drain", 32'(word_valid), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3_clr", 32'(overflow), 32'd0);

    // Drain-and-refill on the same edge
    feed(8'h01, 1'b0);
    pat = 8'hF0;
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, pat[i], 1'b0, 1'b0);
    chk("t4_hold", 32'(word_out), 32'h01);
    step(1'b0, 1'b1, pat[7], 1'b1, 1'b0);
    chk("t4_word", 32'(word_out), 32'hF0);
    chk("t4_ones", 32'(ones_out), 32'd4);
    chk("t4_valid", 32'(word_valid), 32'd1);
    chk("t4_ovf", 32'(overflow), 32'd0);

    // Reset mid-word
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t5_fill5", 32'(fill), 32'd5);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t5_rst_fill", 32'(fill), 32'd0);
    chk("t5_rst_word", 32'(word_out), 32'h0);
    chk("t5_rst_valid", 32'(word_valid), 32'd0);
    feed(8'hAA, 1'b0);
    chk("t5_word", 32'(word_out), 32'hAA);
    chk("t5_ones", 32'(ones_out), 32'd4);

    // Drop coinciding with ovf_clr: set wins
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("t6_ovf_set_wins", 32'(overflow), 32'd1);
    chk("t6_word_kept", 32'(word_out), 32'hAA);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
           1'($urandom), ($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_word_packer.md
# serial_word_packer

Downstream consumer of the serial sequence-detector FSM output. Samples the detector's one-bit result stream (`y_out`) on qualified clock edges, packs consecutive bits into `WIDTH`-bit words, and offers each completed word to a parallel sink over a valid/ready handshake. The `WIDTH`-bit word and its population count (number of detections per word) feed the logging/statistics logic.

## Interface
- `WIDTH`, 8: bits per packed word; legal range 2..32.
- `CW`, $clog2(WIDTH+1): width of `ones_out`; derived, not overridden.
- `FW`, $clog2(WIDTH): width of `fill`; derived, not overridden.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `bit_in`  in  1  serial data, driven from the detector's `y_out`.
- `bit_en`  in  1  qualifies `bit_in`; a bit is consumed only on an edge with `bit_en`=1.
- `word_ready`  in  1  sink accepts the word on an edge with `word_valid`=1 and `word_ready`=1.
- `ovf_clr`  in  1  clears the sticky `overflow` flag.
- `word_out`  out  WIDTH  packed word; first-received bit in `word_out[0]`.
- `ones_out`  out  CW  count of 1s in `word_out`.
- `word_valid`  out  1  output holding register full.
- `fill`  out  FW  bits collected in the current partial word, 0..WIDTH-1.
- `overflow`  out  1  sticky: a completed word was dropped.

## Operation
- Shift register `sr`, bit counter `fill`, one-entry output holding register (`word_out`, `ones_out`, `word_valid`).
- `bit_en`=1 and `fill`<WIDTH-1: `sr[fill]`<=`bit_in`, `fill`<=`fill`+1 (LSB-first packing).
- `bit_en`=1 and `fill`=WIDTH-1 (word completes): assembled word = {`bit_in`, `sr[WIDTH-2:0]`}; `fill`<=0 unconditionally.
  - Load into holding register if it is free: `word_valid`=0, or `word_valid`=1 and `word_ready`=1 on the same edge (drain-and-refill allowed, no bubble).
  - Otherwise drop the word, leave the holding register unchanged, and set `overflow`<=1.
- `bit_en`=0: `sr` and `fill` hold; `bit_in` is ignored.
- Holding register FSM, two states:
  - EMPTY (`word_valid`=0) -> FULL on word completion.
  - FULL -> EMPTY on `word_ready`=1 with no simultaneous completion.
  - FULL -> FULL on `word_ready`=1 with simultaneous completion (new word loaded).
  - FULL -> FULL holding the old word on `word_ready`=0.
- `word_out`/`ones_out` are stable while `word_valid`=1 and not accepted. Values while `word_valid`=0 are don't-care but held (not cleared).
- `ones_out` is the popcount of the assembled word, computed combinationally from the assembled word and registered together with it. It never lags the word.
- `overflow`:
  - Set by a dropped word.
  - Cleared by `ovf_clr`=1.
  - A drop on the same edge as `ovf_clr` leaves `overflow`=1 (set wins).
- `word_ready` while EMPTY has no effect.

## Timing
- Reset (`rst`=1 at an edge) sets `word_out`=0, `ones_out`=0, `word_valid`=0, `fill`=0, `overflow`=0, `sr`=0. Reset has priority over every other input.
- Reset mid-word discards all partial bits. The first enabled bit after reset lands in bit 0.
- Latency: `word_valid` rises in the cycle after the edge that samples the WIDTH-th enabled bit.
- Throughput: one word per WIDTH enabled cycles. No loss while the sink asserts `word_ready` at least once per WIDTH enabled bits.
- `fill` wraps WIDTH-1 -> 0. No state is reachable with `fill`>=WIDTH.
- No combinational path from any input to any output; all outputs are registered.

## Test plan
- Reset, then `bit_en`=1 with bit sequence 1,0,1,1,0,0,0,1, `word_ready`=1 -> one cycle after the 8th bit: `word_out`=8'h8D, `ones_out`=4, `word_valid`=1 for exactly 1 cycle; `overflow`=0.
- Same stream with `bit_en` toggling 1,0,1,0,... -> identical word 8'h8D. `fill` holds on `bit_en`=0 cycles. `word_valid` rises one cycle after the 8th enabled bit.
- `word_ready`=0, feed 8'hFF then 8'h00 continuously -> `word_out`=8'hFF and `ones_out`=8 held. `overflow` rises one cycle after the 16th bit. Then `word_ready`=1 -> `word_valid` falls; `ovf_clr` pulse -> `overflow`=0.
- `word_valid`=1 holding 8'h01; assert `word_ready` on the exact edge the next word 8'hF0 completes -> next cycle `word_out`=8'hF0, `ones_out`=4, `word_valid` stays 1, `overflow`=0.
- Feed 5 bits (`fill`=5), pulse `rst` for one cycle -> `fill`=0 and all outputs 0. The next 8 bits 0,1,0,1,0,1,0,1 produce `word_out`=8'hAA, `ones_out`=4.
- Drop and `ovf_clr` on the same edge -> `overflow`=1 after the edge.
